// File: rtl/boron_pkg.sv
// Shared constants, state encoding and forward S-box for the Boron key sequencer.
package boron_pkg;
  localparam int KEY_W = 80;
  localparam int RK_W  = 64;
  localparam int CNT_W = 5;
  localparam int ROT   = 13;

  typedef enum logic [1:0] {IDLE, EXPAND, EMIT} state_t;

  function automatic logic [3:0] sbox_fwd(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hE;  4'h1: y = 4'h4;  4'h2: y = 4'hB;  4'h3: y = 4'h1;
      4'h4: y = 4'h7;  4'h5: y = 4'h9;  4'h6: y = 4'hC;  4'h7: y = 4'hA;
      4'h8: y = 4'hD;  4'h9: y = 4'h2;  4'hA: y = 4'h0;  4'hB: y = 4'hF;
      4'hC: y = 4'h8;  4'hD: y = 4'h5;  4'hE: y = 4'h3;  default: y = 4'h6;
    endcase
    return y;
  endfunction
endpackage

// File: rtl/enc_key_round.sv
// One forward Boron key-schedule step: rotate left, S-box low nibble, inject counter.
module enc_key_round
  import boron_pkg::*;
(
  input  logic [KEY_W-1:0] i_key,
  input  logic [CNT_W-1:0] i_cnt,
  output logic [KEY_W-1:0] o_key
);
  logic [KEY_W-1:0] w_rot;

  always_comb begin
    w_rot         = {i_key[KEY_W-ROT-1:0], i_key[KEY_W-1:KEY_W-ROT]};
    o_key         = w_rot;
    o_key[3:0]    = sbox_fwd(w_rot[3:0]);
    o_key[63:59]  = w_rot[63:59] ^ i_cnt;
  end
endmodule

// File: rtl/dec_key_sequencer.sv
// Runs the forward key schedule, then emits round keys last-first via the decryption stage.
// Optional KEY_ROUNDTRIP_CHECK_EN: compares the recovered master key against a shadow copy.
module dec_key_sequencer
  import boron_pkg::*;
#(
  parameter int Key_Bit_Size     = 80,
  parameter int Number_of_Rounds = 26,
  parameter int RK_W             = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    key_load,
  input  logic [Key_Bit_Size-1:0] key_in,
  output logic                    key_ready,
  output logic                    rk_valid,
  input  logic                    rk_ready,
  output logic [RK_W-1:0]         rk_out,
  output logic [CNT_W-1:0]        rk_index,
  output logic                    busy,
  output logic [Key_Bit_Size-1:0] dk_prev,
  output logic [CNT_W-1:0]        dk_counter,
`ifdef KEY_ROUNDTRIP_CHECK_EN
  output logic                    key_mismatch,
`endif
  input  logic [Key_Bit_Size-1:0] dk_next
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(Number_of_Rounds - 1);

  state_t                  r_state, w_state_nxt;
  logic [Key_Bit_Size-1:0] r_key;
  logic [CNT_W-1:0]        r_cnt;
  logic [Key_Bit_Size-1:0] w_key_fwd;
  logic                    w_fire;

  enc_key_round u_round (
    .i_key (r_key),
    .i_cnt (r_cnt),
    .o_key (w_key_fwd)
  );

  assign w_fire = (r_state == EMIT) && rk_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (key_load)                    w_state_nxt = EXPAND;
      EXPAND:  if (r_cnt == LAST)               w_state_nxt = EMIT;
      EMIT:    if (w_fire && r_cnt == '0)       w_state_nxt = IDLE;
      default:                                  w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (r_state != IDLE);
    key_ready = !busy;
    rk_valid  = (r_state == EMIT);
  end

  // The counter runs up during expansion and is reused as the descending round index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key <= '0;
      r_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: if (key_load) begin
          r_key <= key_in;
          r_cnt <= CNT_W'(1);
        end
        EXPAND: begin
          r_key <= w_key_fwd;
          if (r_cnt != LAST) r_cnt <= r_cnt + CNT_W'(1);
        end
        EMIT: if (w_fire && r_cnt != '0) begin
          r_key <= dk_next;
          r_cnt <= r_cnt - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign rk_out     = r_key[RK_W-1:0];
  assign rk_index   = r_cnt;
  assign dk_prev    = r_key;
  assign dk_counter = r_cnt;

`ifdef KEY_ROUNDTRIP_CHECK_EN
  logic [Key_Bit_Size-1:0] r_shadow;
  logic                    r_mismatch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow   <= '0;
      r_mismatch <= 1'b0;
    end else if (r_state == IDLE && key_load) begin
      r_shadow   <= key_in;
      r_mismatch <= 1'b0;
    end else if (w_fire && r_cnt == '0) begin
      r_mismatch <= (r_key != r_shadow);
    end
  end

  assign key_mismatch = r_mismatch;
`endif
endmodule

// File: tb/tb_dec_key_sequencer.sv
// Scoreboard bench for dec_key_sequencer; models the decryption key-update stage.
module tb_dec_key_sequencer;
  localparam int N = 26;

  logic        clk = 1'b0, rst_n = 1'b0, key_load = 1'b0, rk_ready = 1'b0;
  logic [79:0] key_in = '0, dk_next, dk_prev, garb = '0;
  logic        key_ready, rk_valid, busy;
  logic [63:0] rk_out;
  logic [4:0]  rk_index, dk_counter;
`ifdef KEY_ROUNDTRIP_CHECK_EN
  logic        key_mismatch;
`endif

  int cmp = 0, mis = 0;
  logic sb_en = 1'b1, garb_en = 1'b0, flip_en = 1'b0, exp_mm = 1'b0, prev_final = 1'b0;

  typedef struct { logic [4:0] idx; logic [63:0] rk; } exp_t;
  exp_t q[$];

  logic [3:0] sb  [16] = '{4'hE,4'h4,4'hB,4'h1,4'h7,4'h9,4'hC,4'hA,4'hD,4'h2,4'h0,4'hF,4'h8,4'h5,4'h3,4'h6};
  logic [3:0] isb [16] = '{4'hA,4'h3,4'h9,4'hE,4'h1,4'hD,4'hF,4'h4,4'hC,4'h5,4'h7,4'h2,4'h6,4'h8,4'h0,4'hB};

  dec_key_sequencer dut (
    .clk(clk), .rst_n(rst_n), .key_load(key_load), .key_in(key_in),
    .key_ready(key_ready), .rk_valid(rk_valid), .rk_ready(rk_ready),
    .rk_out(rk_out), .rk_index(rk_index), .busy(busy),
    .dk_prev(dk_prev), .dk_counter(dk_counter),
`ifdef KEY_ROUNDTRIP_CHECK_EN
    .key_mismatch(key_mismatch),
`endif
    .dk_next(dk_next)
  );

  always #5 clk = ~clk;

  function automatic logic [79:0] fwd(input logic [79:0] k, input logic [4:0] c);
    logic [79:0] r;
    r = (k << 13) | (k >> 67);
    r[3:0] = sb[r[3:0]];
    r[63:59] = r[63:59] ^ c;
    return r;
  endfunction

  function automatic logic [79:0] inv(input logic [79:0] k, input logic [4:0] c);
    logic [79:0] r;
    r = k;
    r[63:59] = r[63:59] ^ c;
    r[3:0] = isb[r[3:0]];
    return (r >> 13) | (r << 67);
  endfunction

  // Decryption-stage model, with hooks for garbage during stalls and a single-bit fault.
  always_comb begin
    dk_next = inv(dk_prev, dk_counter);
    if (flip_en && dk_counter == 5'd5) dk_next[40] = ~dk_next[40];
    if (garb_en) dk_next = garb;
  end

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] expv);
    cmp++;
    if (act !== expv) begin
      mis++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  task automatic push_seq(input logic [79:0] key);
    logic [79:0] k [N];
    k[0] = key;
    for (int c = 1; c < N; c++) k[c] = fwd(k[c-1], 5'(c));
    for (int i = N - 1; i >= 0; i--) q.push_back('{5'(i), k[i][63:0]});
  endtask

  // Monitor: pops and compares on every handshake.
  initial forever begin
    @(negedge clk);
    if (prev_final) begin
      chk("key_ready_after_last", 80'(key_ready), 80'd1);
`ifdef KEY_ROUNDTRIP_CHECK_EN
      chk("key_mismatch_after_last", 80'(key_mismatch), 80'(exp_mm));
`endif
    end
    prev_final = rst_n && rk_valid && rk_ready && rk_index == 5'd0;
    if (rst_n && rk_valid && rk_ready && sb_en) begin
      if (q.size() == 0) begin
        cmp++; mis++;
        $display("FAIL unexpected_rk: got idx %0d rk %h expected none", rk_index, rk_out);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("rk_index", 80'(rk_index), 80'(e.idx));
        chk("rk_out", 80'(rk_out), 80'(e.rk));
      end
    end
  end

  task automatic load(input logic [79:0] key);
    @(posedge clk); #1;
    if (sb_en) push_seq(key);
    key_load = 1'b1; key_in = key;
    @(posedge clk); #1;
    key_load = 1'b0;
  endtask

  task automatic wait_done(input bit rnd);
    int n = 0;
    while (!key_ready && n < 3000) begin
      rk_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1; n++;
    end
    rk_ready = 1'b1;
    if (!key_ready) begin
      cmp++; mis++;
      $display("FAIL done_timeout: got busy expected idle within 3000 cycles");
    end
    chk("queue_drained", 80'(q.size()), 80'd0);
  endtask

  task automatic wait_idx(input logic [4:0] idx);
    int n = 0;
    while (!(rk_valid && rk_index == idx) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 200) begin
      cmp++; mis++;
      $display("FAIL wait_idx_timeout: got idx %0d expected %0d", rk_index, idx);
    end
  endtask

  initial begin
    int lat;
    logic [63:0] hold_rk;

    // Reset state
    #12;
    chk("rst_key_ready", 80'(key_ready), 80'd1);
    chk("rst_rk_valid", 80'(rk_valid), 80'd0);
    chk("rst_busy", 80'(busy), 80'd0);
    chk("rst_rk_out", 80'(rk_out), 80'd0);
    chk("rst_rk_index", 80'(rk_index), 80'd0);
    @(posedge clk); #1; rst_n = 1'b1; rk_ready = 1'b1;

    // Zero key, latency check
    load(80'h0);
    chk("busy_expand", 80'(busy), 80'd1);
    chk("key_ready_expand", 80'(key_ready), 80'd0);
    lat = 1;
    while (!rk_valid && lat < 60) begin @(posedge clk); #1; lat++; end
    chk("first_valid_latency", 80'(lat), 80'd26);
    chk("first_rk_index", 80'(rk_index), 80'd25);
    wait_done(1'b0);
    chk("last_rk_out_zero", 80'(rk_out), 80'h0);

    // All-ones key with random backpressure
    load(80'hFFFF_FFFF_FFFF_FFFF_FFFF);
    wait_done(1'b1);
    chk("last_rk_out_ones", 80'(rk_out), 80'hFFFF_FFFF_FFFF_FFFF);

    // 10-cycle stall at index 20 with garbage on dk_next
    load(80'h0123_4567_89AB_CDEF_1357);
    wait_idx(5'd20);
    rk_ready = 1'b0; garb_en = 1'b1; hold_rk = rk_out;
    for (int i = 0; i < 10; i++) begin
      garb = {$urandom, $urandom, 16'($urandom)};
      @(posedge clk); #1;
      chk("stall_rk_out", 80'(rk_out), 80'(hold_rk));
      chk("stall_rk_index", 80'(rk_index), 80'd20);
    end
    garb_en = 1'b0;
    wait_done(1'b0);

    // Loads during EXPAND and EMIT are ignored
    load(80'hA5A5_5A5A_F00F_0FF0_1234);
    repeat (5) @(posedge clk); #1;
    key_load = 1'b1; key_in = 80'hDEAD_BEEF_0000_1111_2222;
    @(posedge clk); #1; key_load = 1'b0;
    wait_idx(5'd10);
    chk("key_ready_emit", 80'(key_ready), 80'd0);
    key_load = 1'b1; key_in = 80'h1111_2222_3333_4444_5555;
    @(posedge clk); #1; key_load = 1'b0;
    wait_done(1'b0);

    // Mid-sequence reset, then a clean rerun
    load(80'h7777_0000_CAFE_BABE_9999);
    wait_idx(5'd12);
    rst_n = 1'b0; q.delete(); #1;
    chk("mid_rst_rk_valid", 80'(rk_valid), 80'd0);
    chk("mid_rst_key_ready", 80'(key_ready), 80'd1);
    chk("mid_rst_busy", 80'(busy), 80'd0);
    chk("mid_rst_rk_out", 80'(rk_out), 80'd0);
    chk("mid_rst_rk_index", 80'(rk_index), 80'd0);
    chk("mid_rst_dk_prev", dk_prev, 80'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    load(80'h7777_0000_CAFE_BABE_9999);
    wait_done(1'b0);

`ifdef KEY_ROUNDTRIP_CHECK_EN
    // Faulty stage: bit 40 flipped at index 5
    sb_en = 1'b0; flip_en = 1'b1; exp_mm = 1'b1;
    load(80'h0F0F_1E1E_2D2D_3C3C_4B4B);
    wait_done(1'b0);
    chk("mismatch_held", 80'(key_mismatch), 80'd1);
    sb_en = 1'b1; flip_en = 1'b0; exp_mm = 1'b0;
    load(80'h0F0F_1E1E_2D2D_3C3C_4B4B);
    chk("mismatch_cleared_on_load", 80'(key_mismatch), 80'd0);
    wait_done(1'b0);
    chk("mismatch_clean_run", 80'(key_mismatch), 80'd0);
`endif

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
    $finish;
  end
endmodule

// File: doc/dec_key_sequencer.md
Name: dec_key_sequencer

Overview:
Upstream controller for the Boron decryption key-update stage. It accepts an 80-bit master key and runs the forward key schedule to reach the final round key. It then drives the combinational decryption key-update stage once per handshake and emits round keys in reverse order (last round first) to the decryption datapath. It owns the 80-bit key register and the 5-bit round counter that the decryption stage consumes.

Parameters:
Key_Bit_Size, 80, width of key register
Number_of_Rounds, 26, number of round keys emitted (N); N-1 forward updates
RK_W, 64, emitted round-key width (low bits of key register)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
key_load  in  1  master-key valid
key_in  in  80  master key
key_ready  out  1  block idle, can accept key
rk_valid  out  1  round key valid
rk_ready  in  1  consumer accepts round key
rk_out  out  64  current round key = key_reg[63:0]
rk_index  out  5  round index of rk_out, N-1 down to 0
busy  out  1  expanding or emitting
dk_prev  out  80  key register value to the decryption key-update stage
dk_counter  out  5  counter to the decryption key-update stage (= rk_index)
dk_next  in  80  updated key returned by that stage

Behaviour:
- Reset: state IDLE; key_reg=0, cnt=0; key_ready=1; rk_valid=0; busy=0; rk_out=0; rk_index=0.
- IDLE: key_ready=1. When key_load=1, capture key_in into key_reg, set cnt=1, go to EXPAND.
- EXPAND: one forward update per cycle. Rotate key_reg left 13, S-box bits[3:0], then XOR bits[63:59] with cnt.
  - cnt increments each cycle.
  - After the update using cnt=N-1: go to EMIT with rk_index=N-1.
  - Duration is N-1 cycles. With N=26, rk_valid first rises 26 cycles after the load cycle.
- EMIT: rk_valid=1, rk_out=key_reg[63:0].
  - On fire (rk_valid & rk_ready): if rk_index≠0, load key_reg<=dk_next and decrement rk_index.
  - If rk_index=0 at fire: go to IDLE with rk_valid=0 in the next cycle.
  - dk_prev=key_reg and dk_counter=rk_index at all times. dk_next is sampled only on fire.
- Backpressure: while rk_ready=0, rk_out and rk_index hold stable. Stall length is unbounded.
- key_load while busy is ignored, because key_ready=0. Load in the same cycle as the final fire is also ignored; it is accepted one cycle later in IDLE.
- busy=1 in EXPAND and EMIT. key_ready is the complement of busy.
- Counter is 5 bits. N must be ≤31; no wrap occurs.
- rst_n asserted mid-operation aborts immediately to reset values. Partial keys are discarded.
- Forward S-box is the Boron 4-bit S-box, the inverse of the one used by the decryption stage.

Optional Feature:
Macro KEY_ROUNDTRIP_CHECK_EN.
- With it:
  - A shadow 80-bit register holds the master key.
  - On the final fire (rk_index=0), key_reg is compared to the shadow. The result drives extra output key_mismatch (1 bit), registered one cycle after the final fire. It stays high until the next key_load or reset; reset value is 0.
  - A mismatch indicates a schedule/stage inconsistency.
- Without it: no shadow register, no key_mismatch port.

Decomposition:
- Package boron_pkg holds:
  - KEY_W=80, RK_W=64, CNT_W=5, ROT=13
  - forward S-box function/table
  - state enum {IDLE, EXPAND, EMIT}
- Natural sub-module: enc_key_round, the combinational forward update (key, counter -> key). EXPAND uses it once per cycle.

Test Plan:
- key_in=0, rk_ready=1, N=26 -> rk_valid rises exactly 26 cycles after load. 26 keys are emitted with rk_index 25..0. The last rk_out equals 64'h0. key_ready returns the next cycle.
- key_in=80'hFFFF_FFFF_FFFF_FFFF_FFFF, bench model of the decryption stage, random rk_ready -> emitted sequence matches a golden reverse key schedule. The last rk_out is 64'hFFFF_FFFF_FFFF_FFFF.
- rk_ready held 0 for 10 cycles at rk_index=20 -> rk_out/rk_index stable. dk_next is ignored. The sequence resumes unchanged.
- key_load pulsed with a different key during EXPAND and during EMIT -> ignored. The emitted sequence is unchanged.
- rst_n low for 1 cycle at rk_index=12 -> all outputs at reset values. A new load after that produces a full correct sequence.
- With KEY_ROUNDTRIP_CHECK_EN:
  - correct stage model -> key_mismatch=0
  - dk_next bit 40 flipped at rk_index=5 -> key_mismatch=1 one cycle after the final fire, cleared by the next key_load.
